// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-cache refill port (read
// only) and the data port (read/write). Data requests have priority, but an
// instruction request that is kept waiting sees at most MAX_RUN consecutive
// data grants before it is served. A grant lasts until the memory returns
// mem_ready, and each transaction is followed by one idle bubble cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   i_valid, i_addr   instruction request (read only)
//   i_ready, i_rdata  instruction completion pulse and read data
//   d_valid, d_addr,  data request; d_wstrb == 0 means read
//   d_wdata, d_wstrb
//   d_ready, d_rdata  data completion pulse and read data
//   mem_valid, mem_addr, mem_wdata, mem_wstrb   memory request
//   mem_ready, mem_rdata                        memory completion and data
module mem_arbiter #(
  parameter int MAX_RUN  = 4,
  parameter int RUN_BITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [RUN_BITS-1:0] RUN_LIMIT = RUN_BITS'(MAX_RUN);

  state_t              state, state_next;
  logic [RUN_BITS-1:0] run_cnt, run_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_next;
      run_cnt <= run_cnt_next;
    end
  end

  // run_cnt counts data grants completed while an instruction request was
  // waiting; once it reaches MAX_RUN the next contested grant goes to the
  // instruction side.
  always_comb begin
    state_next   = state;
    run_cnt_next = run_cnt;
    case (state)
      IDLE: begin
        if (d_valid && i_valid && (run_cnt >= RUN_LIMIT)) begin
          state_next = GNT_I;
        end else if (d_valid) begin
          state_next = GNT_D;
        end else if (i_valid) begin
          state_next = GNT_I;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          state_next   = IDLE;
          run_cnt_next = '0;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          state_next = IDLE;
          if (!i_valid) begin
            run_cnt_next = '0;
          end else if (run_cnt < RUN_LIMIT) begin
            run_cnt_next = run_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        run_cnt_next = '0;
      end
    endcase
  end

  // Address/data follow the owner's live inputs even if it drops valid
  // early; the grant itself only ends on mem_ready.
  always_comb begin
    mem_valid = (state != IDLE);
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wstrb = 4'd0;
    case (state)
      GNT_I: begin
        mem_addr = i_addr;
      end
      GNT_D: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_wstrb = d_wstrb;
      end
      default: begin
        mem_addr = 32'd0;
      end
    endcase
  end

  assign i_ready = mem_ready && (state == GNT_I);
  assign d_ready = mem_ready && (state == GNT_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural model records who owns
// the memory port and how many data grants an instruction request has been
// kept waiting for; a compare process checks every output each cycle.
// Directed scenarios pin the model with literal expectations, then a
// randomized phase drives both requesters, the memory and reset.
module tb_mem_arbiter;

  localparam int MAX_RUN  = 4;
  localparam int RUN_BITS = 3;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int n_compared   = 0;
  int n_mismatched = 0;

  mem_arbiter #(
    .MAX_RUN (MAX_RUN),
    .RUN_BITS(RUN_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_wstrb  (d_wstrb),
    .d_rdata  (d_rdata),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge so they are stable around posedge.
  task automatic applyStimulus(input logic iv, input logic [31:0] ia,
                               input logic dv, input logic [31:0] da,
                               input logic [31:0] dw, input logic [3:0] ds,
                               input logic mr, input logic [31:0] mrd,
                               input logic r);
    @(negedge clk);
    i_valid   = iv;
    i_addr    = ia;
    d_valid   = dv;
    d_addr    = da;
    d_wdata   = dw;
    d_wstrb   = ds;
    mem_ready = mr;
    mem_rdata = mrd;
    rst       = r;
  endtask

  // Behavioural model: who owns the port, and how many data grants in a row
  // have been completed while the instruction side was asking.
  int m_owner  = OWN_NONE;
  int m_waited = 0;
  bit m_known  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner  = OWN_NONE;
      m_waited = 0;
      m_known  = 1'b1;
    end else if (m_owner == OWN_NONE) begin
      if (i_valid && (!d_valid || m_waited >= MAX_RUN)) m_owner = OWN_I;
      else if (d_valid) m_owner = OWN_D;
    end else if (mem_ready) begin
      if (m_owner == OWN_D && i_valid) m_waited = (m_waited + 1 > MAX_RUN) ? MAX_RUN : m_waited + 1;
      else m_waited = 0;
      m_owner = OWN_NONE;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    #2;
    if (m_known) begin
      checkOutput("mem_valid", 32'(mem_valid), 32'(m_owner != OWN_NONE));
      checkOutput("mem_addr", mem_addr,
                  (m_owner == OWN_I) ? i_addr : (m_owner == OWN_D) ? d_addr : 32'd0);
      checkOutput("mem_wdata", mem_wdata, (m_owner == OWN_D) ? d_wdata : 32'd0);
      checkOutput("mem_wstrb", 32'(mem_wstrb), (m_owner == OWN_D) ? 32'(d_wstrb) : 32'd0);
      checkOutput("i_ready", 32'(i_ready), 32'(mem_ready && m_owner == OWN_I));
      checkOutput("d_ready", 32'(d_ready), 32'(mem_ready && m_owner == OWN_D));
      checkOutput("i_rdata", i_rdata, mem_rdata);
      checkOutput("d_rdata", d_rdata, mem_rdata);
    end
  end

  int grants[$];
  int exp_grants[10];
  bit iv_r, dv_r, i_done, d_done;
  logic [31:0] ia_r, da_r, dw_r;
  logic [3:0]  ds_r;

  initial begin
    i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_ready = 0; mem_rdata = 0; rst = 1;

    // Reset
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("reset_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("reset_i_ready", 32'(i_ready), 32'd0);
    checkOutput("reset_d_ready", 32'(d_ready), 32'd0);

    // Single instruction read
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("i_latency_mem_valid", 32'(mem_valid), 32'd0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("i_mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("i_mem_addr", mem_addr, 32'h100);
    checkOutput("i_mem_wstrb", 32'(mem_wstrb), 32'd0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    #2;
    checkOutput("i_ready_pulse", 32'(i_ready), 32'd1);
    checkOutput("i_rdata_value", i_rdata, 32'hDEADBEEF);
    checkOutput("i_d_ready_low", 32'(d_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("i_done_idle", 32'(mem_valid), 32'd0);
    checkOutput("i_ready_once", 32'(i_ready), 32'd0);

    // Data write
    applyStimulus(0, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 0, 0, 0);
    #2;
    checkOutput("d_mem_addr", mem_addr, 32'h2000);
    checkOutput("d_mem_wdata", mem_wdata, 32'h12345678);
    checkOutput("d_mem_wstrb", 32'(mem_wstrb), 32'h3);
    applyStimulus(0, 0, 1, 32'h2000, 32'h12345678, 4'b0011, 1, 0, 0);
    #2 checkOutput("d_ready_pulse", 32'(d_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("d_done_idle", 32'(mem_valid), 32'd0);

    // Both requesters at once: data first, instruction after a bubble
    applyStimulus(1, 32'h300, 1, 32'h4000, 0, 0, 0, 0, 0);
    #2 checkOutput("both_latency", 32'(mem_valid), 32'd0);
    applyStimulus(1, 32'h300, 1, 32'h4000, 0, 0, 0, 0, 0);
    #2 checkOutput("both_first_is_data", mem_addr, 32'h4000);
    applyStimulus(1, 32'h300, 1, 32'h4000, 0, 0, 1, 32'h11, 0);
    #2 checkOutput("both_d_ready", 32'(d_ready), 32'd1);
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("both_bubble", 32'(mem_valid), 32'd0);
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("both_second_is_instr", mem_addr, 32'h300);
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 32'h55, 0);
    #2 checkOutput("both_i_ready", 32'(i_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation bound: both held, memory always ready
    exp_grants = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_D, OWN_D, OWN_I};
    for (int c = 0; c < 60 && grants.size() < 10; c++) begin
      applyStimulus(1, 32'h8000, 1, 32'h7000, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 0);
      #2;
      if (mem_valid) grants.push_back((mem_addr == 32'h7000) ? OWN_D : OWN_I);
    end
    checkOutput("starve_grant_count", 32'(grants.size()), 32'd10);
    for (int g = 0; g < 10; g++) begin
      checkOutput($sformatf("starve_grant_%0d", g),
                  (g < grants.size()) ? 32'(grants[g]) : 32'hFFFFFFFF, 32'(exp_grants[g]));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Spurious mem_ready in IDLE, then data drops valid mid-grant
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h9, 0);
    #2;
    checkOutput("spur_i_ready", 32'(i_ready), 32'd0);
    checkOutput("spur_d_ready", 32'(d_ready), 32'd0);
    applyStimulus(0, 0, 1, 32'h5000, 32'h1, 4'h0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h5000, 32'h1, 4'h0, 0, 0, 0);
    #2 checkOutput("drop_grant_held", 32'(mem_valid), 32'd1);
    applyStimulus(0, 0, 0, 32'h5000, 32'h1, 4'h0, 0, 0, 0);
    #2 checkOutput("drop_addr_live", mem_addr, 32'h5000);
    applyStimulus(0, 0, 0, 32'h5000, 32'h1, 4'h0, 1, 32'h77, 0);
    #2 checkOutput("drop_d_ready", 32'(d_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("drop_idle", 32'(mem_valid), 32'd0);

    // Reset while an instruction grant is in flight
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h600, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("rst_pre_mem_valid", 32'(mem_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("rst_mem_valid_low", 32'(mem_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD, 0);
    #2 checkOutput("rst_late_i_ready", 32'(i_ready), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    iv_r = 0; dv_r = 0; i_done = 0; d_done = 0;
    ia_r = 0; da_r = 0; dw_r = 0; ds_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if (iv_r && i_done) iv_r = 0;
      else if (!iv_r && $urandom_range(2) == 0) begin
        iv_r = 1;
        ia_r = $urandom;
      end
      if (dv_r && d_done) dv_r = 0;
      else if (dv_r && $urandom_range(19) == 0) dv_r = 0;
      else if (!dv_r && $urandom_range(2) == 0) begin
        dv_r = 1;
        da_r = $urandom;
        dw_r = $urandom;
        ds_r = 4'($urandom);
      end
      applyStimulus(iv_r, ia_r, dv_r, da_r, dw_r, ds_r, $urandom_range(2) == 0,
                    $urandom, $urandom_range(199) == 0);
      #2;
      i_done = i_ready;
      d_done = d_ready;
    end

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
